// File: rtl/br_predictor.sv
// br_predictor: direct-mapped branch target buffer for the pipelined MIPS core.
// Each entry holds a valid bit, a tag, a target and a saturating counter.
// Indexing is bimodal (MODE 0) or gshare (MODE 1, index XOR global history).
// A sequential clear engine walks the table one entry per cycle. Two
// saturating performance counters track lookups and mispredicts.
//
// Ports:
//   CLK, nRST          clock, synchronous active-low reset
//   pc                 fetch address looked up combinationally
//   pred_hit/taken     lookup hit and predicted direction
//   pred_target        stored target of the looked-up entry
//   pred_index         index used, piped by the datapath to the update port
//   upd_valid/index/pc/taken/target/mispredict
//                      branch resolution from the memory stage
//   clr_req            pulse to start a table clear
//   busy               clear in progress
//   perf_lookups       saturating count of non-busy lookup cycles
//   perf_mispred       saturating count of mispredict updates
module br_predictor #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned MODE     = 0,
    localparam int unsigned IDX     = $clog2(ENTRIES)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [31:0]     pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    output logic [IDX-1:0]  pred_index,
    input  logic            upd_valid,
    input  logic [IDX-1:0]  upd_index,
    input  logic [31:0]     upd_pc,
    input  logic            upd_taken,
    input  logic [31:0]     upd_target,
    input  logic            upd_mispredict,
    input  logic            clr_req,
    output logic            busy,
    output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_mispred
);

    localparam int unsigned TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [IDX-1:0]      ptr_q, ptr_d;
    logic [IDX-1:0]      ghr_q, ghr_d;
    logic [31:0]         perf_lookups_q, perf_lookups_d;
    logic [31:0]         perf_mispred_q, perf_mispred_d;
    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [IDX-1:0]      look_idx;
    logic                look_hit;
    logic                upd_hit;
    logic                unused_bits;

    assign unused_bits  = ^{pc[1:0], upd_pc[IDX+1:0]};
    assign busy         = (state_q == S_CLEAR);
    assign perf_lookups = perf_lookups_q;
    assign perf_mispred = perf_mispred_q;

    // Lookup path
    always_comb begin
        look_idx = pc[IDX+1:2];
        if (MODE == 1) begin
            look_idx = pc[IDX+1:2] ^ ghr_q;
        end
        look_hit    = valid_q[look_idx] && (tag_q[look_idx] == pc[31:IDX+2]);
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        pred_index  = '0;
        if (state_q == S_IDLE) begin
            pred_hit    = look_hit;
            pred_taken  = look_hit && ctr_q[look_idx][CTR_BITS-1];
            pred_target = target_q[look_idx];
            pred_index  = look_idx;
        end
    end

    // Update / clear engine / perf counters
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        ghr_d          = ghr_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        target_d       = target_q;
        ctr_d          = ctr_q;
        perf_lookups_d = perf_lookups_q;
        perf_mispred_d = perf_mispred_q;
        upd_hit        = valid_q[upd_index] && (tag_q[upd_index] == upd_pc[31:IDX+2]);

        if (state_q == S_IDLE && perf_lookups_q != '1) begin
            perf_lookups_d = perf_lookups_q + 32'd1;
        end
        if (upd_valid && upd_mispredict && perf_mispred_q != '1) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                // A clear request wins over a same-cycle update.
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end else if (upd_valid) begin
                    // Shift in the outcome; the cast keeps the low IDX bits,
                    // which also covers IDX == 1.
                    ghr_d = IDX'({ghr_q, upd_taken});
                    if (upd_taken) begin
                        target_d[upd_index] = upd_target;
                        if (upd_hit) begin
                            if (ctr_q[upd_index] != '1) begin
                                ctr_d[upd_index] = ctr_q[upd_index] + CTR_BITS'(1);
                            end
                        end else begin
                            valid_d[upd_index] = 1'b1;
                            tag_d[upd_index]   = upd_pc[31:IDX+2];
                            ctr_d[upd_index]   = CTR_WT;
                        end
                    end else if (upd_hit && ctr_q[upd_index] != '0) begin
                        ctr_d[upd_index] = ctr_q[upd_index] - CTR_BITS'(1);
                    end
                end
            end
            S_CLEAR: begin
                valid_d[ptr_q] = 1'b0;
                ctr_d[ptr_q]   = CTR_WNT;
                ptr_d          = ptr_q + IDX'(1);
                if (ptr_q == IDX'(ENTRIES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            ghr_q          <= '0;
            perf_lookups_q <= '0;
            perf_mispred_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            ghr_q          <= ghr_d;
            perf_lookups_q <= perf_lookups_d;
            perf_mispred_q <= perf_mispred_d;
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            target_q       <= target_d;
            ctr_q          <= ctr_d;
        end
    end

endmodule

// File: tb/tb_br_predictor.sv
module tb_br_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        upd_valid0, clr_req0;
    logic [1:0]  upd_index0;
    logic        hit0, taken0, busy0;
    logic [31:0] target0, look0, misp0;
    logic [1:0]  index0;

    logic        upd_valid1, clr_req1;
    logic [2:0]  upd_index1;
    logic        hit1, taken1, busy1;
    logic [31:0] target1, look1, misp1;
    logic [2:0]  index1;

    always #5 CLK = ~CLK;

    br_predictor #(.ENTRIES(4), .CTR_BITS(2), .MODE(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .pc(pc),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(target0), .pred_index(index0),
        .upd_valid(upd_valid0), .upd_index(upd_index0), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clr_req(clr_req0), .busy(busy0), .perf_lookups(look0), .perf_mispred(misp0)
    );

    br_predictor #(.ENTRIES(8), .CTR_BITS(2), .MODE(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .pc(pc),
        .pred_hit(hit1), .pred_taken(taken1), .pred_target(target1), .pred_index(index1),
        .upd_valid(upd_valid1), .upd_index(upd_index1), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .clr_req(clr_req1), .busy(busy1), .perf_lookups(look1), .perf_mispred(misp1)
    );

    typedef enum int {K_HIT0, K_TAKEN0, K_TARGET0, K_INDEX0, K_BUSY0, K_LOOK0, K_MISP0,
                      K_HIT1, K_INDEX1, K_BUSY1} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_HIT0:    return {31'd0, hit0};
            K_TAKEN0:  return {31'd0, taken0};
            K_TARGET0: return target0;
            K_INDEX0:  return {30'd0, index0};
            K_BUSY0:   return {31'd0, busy0};
            K_LOOK0:   return look0;
            K_MISP0:   return misp0;
            K_HIT1:    return {31'd0, hit1};
            K_INDEX1:  return {29'd0, index1};
            K_BUSY1:   return {31'd0, busy1};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        logic [31:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.kind);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_v(input string n, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd0(input logic [31:0] p, input logic [1:0] i, input logic t,
                        input logic [31:0] tgt, input logic m);
        upd_valid0     = 1'b1;
        upd_index0     = i;
        upd_pc         = p;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; pc = 32'h40;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
        upd_valid0 = 1'b0; clr_req0 = 1'b0; upd_index0 = '0;
        upd_valid1 = 1'b0; clr_req1 = 1'b0; upd_index1 = '0;
        step(); step();
        expect_v("rst_hit", K_HIT0, 0);
        expect_v("rst_taken", K_TAKEN0, 0);
        expect_v("rst_index", K_INDEX0, 0);
        expect_v("rst_target", K_TARGET0, 0);
        expect_v("rst_busy", K_BUSY0, 0);
        expect_v("rst_lookups", K_LOOK0, 0);
        expect_v("rst_mispred", K_MISP0, 0);
        expect_v("rst_index_gshare", K_INDEX1, 0);
        expect_v("rst_busy_gshare", K_BUSY1, 0);
        nRST = 1'b1;
        step(); step(); step();
        expect_v("lookups_after_3", K_LOOK0, 3);

        upd0(32'h40, 2'd0, 1'b1, 32'h80, 1'b1);
        expect_v("same_cycle_hit", K_HIT0, 0);
        step();
        upd_valid0 = 1'b0; upd_mispredict = 1'b0;
        expect_v("alloc_hit", K_HIT0, 1);
        expect_v("alloc_taken", K_TAKEN0, 1);
        expect_v("alloc_target", K_TARGET0, 32'h80);
        expect_v("mispred_1", K_MISP0, 1);

        upd0(32'h40, 2'd0, 1'b0, 32'h0, 1'b0);
        step(); expect_v("ctr1_taken", K_TAKEN0, 0);
        step(); expect_v("ctr0_taken", K_TAKEN0, 0); expect_v("ctr0_hit", K_HIT0, 1);
        step(); expect_v("ctr0_sat_taken", K_TAKEN0, 0);
        upd_taken = 1'b1; upd_target = 32'h80;
        step(); expect_v("ctr_up1_taken", K_TAKEN0, 0);
        step(); expect_v("ctr_up2_taken", K_TAKEN0, 1);
        step();
        step(); expect_v("ctr3_sat_taken", K_TAKEN0, 1);
        upd_taken = 1'b0;
        step(); expect_v("ctr3_dec_taken", K_TAKEN0, 1);
        upd_valid0 = 1'b0;

        upd0(32'h50, 2'd0, 1'b1, 32'h90, 1'b0);
        step();
        upd_valid0 = 1'b0; pc = 32'h40;
        expect_v("conflict_old_hit", K_HIT0, 0);
        step();
        pc = 32'h50;
        expect_v("conflict_new_hit", K_HIT0, 1);
        expect_v("conflict_new_target", K_TARGET0, 32'h90);
        expect_v("conflict_new_taken", K_TAKEN0, 1);
        upd0(32'h60, 2'd0, 1'b0, 32'h0, 1'b0);
        step();
        upd_valid0 = 1'b0;
        expect_v("nt_miss_hit", K_HIT0, 1);
        expect_v("nt_miss_taken", K_TAKEN0, 1);
        expect_v("nt_miss_target", K_TARGET0, 32'h90);
        step();
        pc = 32'h4C;
        expect_v("index_4c", K_INDEX0, 3);

        for (int i = 0; i < 4; i++) begin
            upd0(32'h100 + 32'(4 * i), 2'(i), 1'b1, 32'h1000 + 32'(16 * i), 1'b0);
            step();
        end
        upd_valid0 = 1'b0; pc = 32'h10C;
        expect_v("fill_hit", K_HIT0, 1);
        expect_v("fill_target", K_TARGET0, 32'h1030);
        step();
        pc = 32'h104; clr_req0 = 1'b1;
        upd0(32'h204, 2'd1, 1'b1, 32'h300, 1'b1);
        expect_v("clr_req_busy", K_BUSY0, 0);
        expect_v("clr_req_hit", K_HIT0, 1);
        step();
        clr_req0 = 1'b0; upd_valid0 = 1'b0; upd_mispredict = 1'b0;
        expect_v("clr_c1_busy", K_BUSY0, 1);
        expect_v("clr_c1_hit", K_HIT0, 0);
        expect_v("clr_c1_taken", K_TAKEN0, 0);
        expect_v("clr_c1_index", K_INDEX0, 0);
        expect_v("clr_c1_target", K_TARGET0, 0);
        step();
        expect_v("clr_c2_busy", K_BUSY0, 1);
        upd0(32'h100, 2'd0, 1'b1, 32'h500, 1'b1);
        step();
        upd_valid0 = 1'b0; upd_mispredict = 1'b0;
        expect_v("clr_c3_busy", K_BUSY0, 1);
        expect_v("clr_c3_taken", K_TAKEN0, 0);
        step();
        expect_v("clr_c4_busy", K_BUSY0, 1);
        step();
        pc = 32'h100;
        expect_v("clr_done_busy", K_BUSY0, 0);
        expect_v("clr_mispred", K_MISP0, 3);
        expect_v("clr_hit_100", K_HIT0, 0);
        step(); pc = 32'h104; expect_v("clr_hit_104", K_HIT0, 0);
        step(); pc = 32'h108; expect_v("clr_hit_108", K_HIT0, 0);
        step(); pc = 32'h10C; expect_v("clr_hit_10c", K_HIT0, 0);
        step(); pc = 32'h204; expect_v("clr_hit_204", K_HIT0, 0);
        step();

        upd_valid1 = 1'b1; upd_taken = 1'b1; upd_pc = 32'h04; upd_index1 = 3'd1;
        upd_target = 32'h44;
        step(); step(); step();
        upd_valid1 = 1'b0; pc = 32'h04;
        expect_v("gshare_index_111", K_INDEX1, 6);
        upd_valid1 = 1'b1; upd_index1 = 3'd6;
        step();
        upd_valid1 = 1'b0;
        expect_v("gshare_hit", K_HIT1, 1);
        expect_v("gshare_index_still", K_INDEX1, 6);
        upd_valid1 = 1'b1; upd_taken = 1'b0;
        step();
        upd_valid1 = 1'b0;
        expect_v("gshare_index_110", K_INDEX1, 7);
        clr_req1 = 1'b1;
        step();
        clr_req1 = 1'b0;
        expect_v("gshare_clr_busy", K_BUSY1, 1);
        expect_v("gshare_clr_index", K_INDEX1, 0);
        repeat (7) step();
        expect_v("gshare_clr_c8_busy", K_BUSY1, 1);
        step();
        expect_v("gshare_clr_done", K_BUSY1, 0);
        expect_v("gshare_ghr_zero_index", K_INDEX1, 1);
        expect_v("gshare_clr_hit", K_HIT1, 0);

        clr_req0 = 1'b1;
        step();
        clr_req0 = 1'b0;
        step();
        nRST = 1'b0;
        step();
        nRST = 1'b1; pc = 32'h10C;
        expect_v("midclr_rst_busy", K_BUSY0, 0);
        expect_v("midclr_rst_lookups", K_LOOK0, 0);
        expect_v("midclr_rst_mispred", K_MISP0, 0);
        expect_v("midclr_rst_hit", K_HIT0, 0);
        step();

        force dut0.perf_mispred_d = 32'hFFFF_FFFF;
        step();
        release dut0.perf_mispred_d;
        upd0(32'h700, 2'd3, 1'b0, 32'h0, 1'b1);
        expect_v("mispred_forced", K_MISP0, 32'hFFFF_FFFF);
        step();
        upd_valid0 = 1'b0; upd_mispredict = 1'b0;
        expect_v("mispred_saturated", K_MISP0, 32'hFFFF_FFFF);
        step(); step();

        if (checks < 12) begin
            $display("FAIL check_count: got %0d, expected at least 12", checks);
            errors++;
        end
        if (errors != 0) begin
            $display("FAIL summary: got %0d errors, expected 0", errors);
        end else begin
            $display("PASS");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_predictor.md
# br_predictor

Parametrised branch predictor for the pipelined MIPS core, succeeding the fixed 4-entry `br_predict`. It holds a direct-mapped branch target buffer with N-bit saturating counters and supports bimodal or gshare indexing. The instruction fetch stage looks it up combinationally each cycle, and the memory stage updates it when a branch resolves. A sequential clear engine invalidates the table on request, and two performance counters track lookups and mispredicts.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `CTR_BITS`, 2: saturating counter width, ≥1.
- `MODE`, 0: 0 = bimodal, 1 = gshare (index XOR global history).
- `CLK` in 1: clock; all state updates on rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `pc` in 32: fetch address being looked up.
- `pred_hit` out 1: valid entry with matching tag.
- `pred_taken` out 1: predict taken.
- `pred_target` out 32: stored target.
- `pred_index` out IDX: index used for this lookup; the datapath pipes it to the memory stage.
- `upd_valid` in 1: a branch resolved this cycle.
- `upd_index` in IDX: index returned at that branch's lookup.
- `upd_pc` in 32: branch PC.
- `upd_taken` in 1: actual outcome.
- `upd_target` in 32: actual branch target.
- `upd_mispredict` in 1: datapath flagged a mispredict (direction or target).
- `clr_req` in 1: pulse to start a table clear.
- `busy` out 1: clear in progress.
- `perf_lookups` out 32: count of cycles with a lookup while not busy; saturating.
- `perf_mispred` out 32: count of `upd_valid & upd_mispredict` cycles; saturating.

## Operation
- Entry fields: `valid`, `tag = pc[31:IDX+2]`, `target[31:0]`, `ctr[CTR_BITS-1:0]`.
- Global history `ghr` is IDX bits wide.
- Lookup (combinational, state IDLE):
  - MODE 0: `idx = pc[IDX+1:2]`.
  - MODE 1: `idx = pc[IDX+1:2] ^ ghr`.
  - `pred_hit = valid[idx] & tag match`.
  - `pred_taken = pred_hit & ctr[MSB]`.
  - `pred_target` = stored target of `idx`.
  - `pred_index = idx`.
- Update on `upd_valid` (state IDLE), applied to entry `upd_index`:
  - Taken, tag hit: set `target`, increment `ctr`, saturating at all-ones.
  - Taken, miss or invalid: allocate with `valid=1`, new tag, target, and `ctr = 2^(CTR_BITS-1)` (weakly taken).
  - Not taken, tag hit: decrement `ctr`, saturating at 0.
  - Not taken, miss: entry unchanged.
- `ghr <= {ghr[IDX-2:0], upd_taken}` on every `upd_valid`, in both modes. If IDX = 1, `ghr <= upd_taken`.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on `clr_req`: `ptr <= 0`, `ghr <= 0`.
  - In CLEAR, each cycle: `valid[ptr] <= 0`, `ctr[ptr] <= 2^(CTR_BITS-1)-1` (weakly not-taken), `ptr++`.
  - CLEAR → IDLE after writing `ptr = ENTRIES-1`.
  - `busy = (state == CLEAR)`.
  - While busy: `pred_hit = pred_taken = 0`, `pred_index = 0`, `pred_target = 0`; `upd_valid` is ignored and does not affect `ghr` (the mispredict counter still counts); `clr_req` is ignored.
- Performance counters:
  - `perf_lookups` increments every IDLE cycle, since fetch looks up every cycle.
  - Both counters saturate at 0xFFFF_FFFF.

## Timing
- Lookup has zero latency: outputs are combinational from `pc` and the current state.
- Update is visible to lookups on the cycle after `upd_valid`.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents.
- Same-cycle `clr_req` and `upd_valid` in IDLE: the update is dropped, and the clear starts next cycle with `ghr = 0`.
- A clear takes exactly ENTRIES cycles. `busy` is high from the cycle after `clr_req` for ENTRIES cycles.
- Reset (`nRST = 0` at a rising edge, taking priority over everything, including mid-clear):
  - All `valid = 0`, all `ctr` weakly not-taken, `ghr = 0`.
  - State IDLE, `ptr = 0`, perf counters 0.
  - Outputs: `pred_hit = 0`, `pred_taken = 0`, `busy = 0`.
  - `pred_target` and `target` contents reset to 0.

## Test plan
All scenarios use ENTRIES=4, CTR_BITS=2 unless stated.
- Reset, then lookup `pc = 0x40` → `pred_hit = 0`, `pred_taken = 0`, `pred_index = 0`, `busy = 0`, perf counters 0 before the first counted cycle.
- MODE 0: update idx 0, `pc = 0x40`, taken, target `0x80` → next-cycle lookup of `0x40` gives hit=1, taken=1 (ctr=2), target `0x80`. Then two not-taken updates → ctr 0, taken=0, hit=1. A third not-taken update keeps ctr at 0.
- Tag conflict: allocate `0x40`, then resolve `0x50` (same idx 0) taken with target `0x90` → lookup `0x40` hit=0; lookup `0x50` hit=1, target `0x90`. A not-taken update of `0x60` at idx 0 leaves the entry unchanged.
- MODE 1: three taken updates → `ghr = 3'b111` (ENTRIES=8). Lookup `pc = 0x04` → `pred_index = 1 ^ 7 = 6`.
- Clear: fill all 4 entries, pulse `clr_req` together with `upd_valid` → busy for exactly 4 cycles, update dropped, lookups during busy give taken=0. Afterwards all lookups give hit=0 and `ghr = 0`.
- Assert `nRST = 0` during cycle 2 of a clear → next cycle busy=0, IDLE, perf counters 0. Counter saturation checked by forcing `perf_mispred` to 0xFFFF_FFFF, then issuing a mispredict update → stays 0xFFFF_FFFF.
